serial_frame_receiver: RTL and testbench

Asynchronous serial receiver that sits directly upstream of the string detector. It recovers 8N1 bytes from a single serial line using a per-bit clock count. Each byte is presented with a one-cycle valid strobe. It also tracks the length-prefixed frame structure: the first byte is the payload length, followed by that many payload bytes. Its byte and strobe outputs drive the detector's received-string and receive-flag inputs directly.

---
 rtl/serial_frame_receiver_pkg.sv | 20 ++
 rtl/serial_frame_receiver_rx_synchronizer.sv | 30 +++
 rtl/serial_frame_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver.
// Holds the bit-level FSM state type, the data width and the default baud divisor.
// Optional feature macro: PARITY_RX_EN adds the even-parity state to the FSM.
package serial_frame_receiver_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef PARITY_RX_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } rx_state_e;

endpackage

// File: rtl/serial_frame_receiver_rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk_i - system clock
//   rst_i - synchronous active-high reset; both flops reset to 1 (line idle level)
//   d_i   - asynchronous input
//   q_o   - synchronized output
module serial_frame_receiver_rx_synchronizer (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/serial_frame_receiver.sv
// 8N1 serial receiver with length-prefixed frame tracking.
// Recovers bytes from Rx using a per-bit clock count, strobes each good byte and
// flags whether it is a frame length header or the final byte of a frame.
// Ports:
//   Clk, Reset   - clock and synchronous active-high reset
//   Rx           - asynchronous serial line, idle high
//   Data_byte    - last good byte, held until the next one
//   Receive_flag - one-cycle strobe, Data_byte valid
//   Is_header    - with Receive_flag, byte is a frame length
//   Frame_done   - with Receive_flag, last byte of a frame
//   Frame_error  - one-cycle strobe on bad stop bit (or bad parity)
//   Busy         - FSM not idle
// Optional feature macro: PARITY_RX_EN adds one even-parity bit after the data bits.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Data_byte,
  output logic       Receive_flag,
  output logic       Is_header,
  output logic       Frame_done,
  output logic       Frame_error,
  output logic       Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfM1  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state_d, state_q;
  logic [CntW-1:0]      cnt_d, cnt_q;
  logic [BitW-1:0]      bit_cnt_d, bit_cnt_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [7:0]           data_byte_d, data_byte_q;
  logic [7:0]           rem_d, rem_q;
  logic                 in_frame_d, in_frame_q;
  logic                 receive_flag_d, receive_flag_q;
  logic                 is_header_d, is_header_q;
  logic                 frame_done_d, frame_done_q;
  logic                 frame_error_d, frame_error_q;
  logic                 par_bad;

  serial_frame_receiver_rx_synchronizer u_rx_synchronizer (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (Rx),
    .q_o   (rxs)
  );

`ifdef PARITY_RX_EN
  logic par_err_d, par_err_q;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CntW'(1);
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    data_byte_d    = data_byte_q;
    rem_d          = rem_q;
    in_frame_d     = in_frame_q;
    receive_flag_d = 1'b0;
    is_header_d    = 1'b0;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
`ifdef PARITY_RX_EN
    par_err_d      = par_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d   = StStart;
          bit_cnt_d = '0;
`ifdef PARITY_RX_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          // A line that is high again at mid-start is a glitch, not a byte.
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == LastBit) begin
`ifdef PARITY_RX_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef PARITY_RX_EN
      StParity: begin
        if (cnt_q == FullM1) begin
          cnt_d     = '0;
          // Even parity: the parity bit equals the XOR of the data bits.
          par_err_d = (rxs != ^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (!rxs || par_bad) begin
            frame_error_d = 1'b1;
            in_frame_d    = 1'b0;
            state_d       = rxs ? StIdle : StWaitHigh;
          end else begin
            state_d        = StIdle;
            data_byte_d    = shift_q;
            receive_flag_d = 1'b1;
            if (!in_frame_q) begin
              is_header_d = 1'b1;
              rem_d       = shift_q;
              if (shift_q == 8'd0) begin
                frame_done_d = 1'b1;
              end else begin
                in_frame_d = 1'b1;
              end
            end else begin
              rem_d = rem_q - 8'd1;
              if (rem_q == 8'd1) begin
                frame_done_d = 1'b1;
                in_frame_d   = 1'b0;
              end
            end
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      data_byte_q    <= '0;
      rem_q          <= '0;
      in_frame_q     <= 1'b0;
      receive_flag_q <= 1'b0;
      is_header_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef PARITY_RX_EN
      par_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      data_byte_q    <= data_byte_d;
      rem_q          <= rem_d;
      in_frame_q     <= in_frame_d;
      receive_flag_q <= receive_flag_d;
      is_header_q    <= is_header_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
`ifdef PARITY_RX_EN
      par_err_q      <= par_err_d;
`endif
    end
  end

  assign Data_byte    = data_byte_q;
  assign Receive_flag = receive_flag_q;
  assign Is_header    = is_header_q;
  assign Frame_done   = frame_done_q;
  assign Frame_error  = frame_error_q;
  assign Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: a serial line driver, an event monitor
// and a frame-level reference model that predicts every strobe and its cycle.
module tb_serial_frame_receiver;

  localparam int unsigned CPB = 16;
  localparam int unsigned H   = CPB / 2;
`ifdef PARITY_RX_EN
  localparam int unsigned NB = 10;
`else
  localparam int unsigned NB = 9;
`endif

  logic       Clk, Reset, Rx;
  logic [7:0] Data_byte;
  logic       Receive_flag, Is_header, Frame_done, Frame_error, Busy;

  int cyc;
  int n_tests, n_fail;

  typedef struct {
    int         cyc;
    bit         rf;
    bit         err;
    bit         hdr;
    bit         done;
    logic [7:0] data;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  // Reference frame state: are we inside a frame, how many payload bytes remain.
  bit         m_in_frame;
  int         m_left;
  logic [7:0] m_last;

  serial_frame_receiver #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Rx           (Rx),
    .Data_byte    (Data_byte),
    .Receive_flag (Receive_flag),
    .Is_header    (Is_header),
    .Frame_done   (Frame_done),
    .Frame_error  (Frame_error),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Receive_flag || Frame_error || Is_header || Frame_done) begin
      ev_t e;
      e.cyc  = cyc;
      e.rf   = Receive_flag;
      e.err  = Frame_error;
      e.hdr  = Is_header;
      e.done = Frame_done;
      e.data = Data_byte;
      got_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge Clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_left     = 0;
    m_last     = 8'h00;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Rx    = 1'b1;
    wait_cycles(2);
    check("reset_data", 32'(Data_byte), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    Reset = 1'b0;
    model_reset();
    wait_cycles(3);
  endtask

  // Sends one byte; stop_low > 0 holds the stop bit low for that many bit times.
  task automatic send_byte(input logic [7:0] b, input int stop_low, input bit par_bad);
    ev_t e;
    bit  err;
    int  t0;
    t0     = cyc;
    err    = (stop_low > 0);
`ifdef PARITY_RX_EN
    err    = err || par_bad;
`endif
    e.cyc  = t0 + 3 + int'(H) + int'(NB * CPB);
    e.hdr  = 1'b0;
    e.done = 1'b0;
    if (err) begin
      e.rf       = 1'b0;
      e.err      = 1'b1;
      e.data     = m_last;
      m_in_frame = 1'b0;
    end else begin
      e.rf   = 1'b1;
      e.err  = 1'b0;
      e.data = b;
      m_last = b;
      if (!m_in_frame) begin
        e.hdr = 1'b1;
        if (b == 8'd0) begin
          e.done = 1'b1;
        end else begin
          m_in_frame = 1'b1;
          m_left     = int'(b);
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          e.done     = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end
    exp_q.push_back(e);

    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARITY_RX_EN
    drive_bit((^b) ^ par_bad);
`endif
    if (stop_low > 0) begin
      Rx = 1'b0;
      wait_cycles(stop_low * int'(CPB));
      check("wait_high_busy", 32'(Busy), 32'h1);
      drive_bit(1'b1);
      check("wait_high_exit", 32'(Busy), 32'h0);
    end else begin
      drive_bit(1'b1);
    end
  endtask

  task automatic verify(input string tag);
    int n;
    check({tag, ":count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ":cyc"},  32'(got_q[i].cyc),  32'(exp_q[i].cyc));
      check({tag, ":rf"},   32'(got_q[i].rf),   32'(exp_q[i].rf));
      check({tag, ":err"},  32'(got_q[i].err),  32'(exp_q[i].err));
      check({tag, ":hdr"},  32'(got_q[i].hdr),  32'(exp_q[i].hdr));
      check({tag, ":done"}, 32'(got_q[i].done), 32'(exp_q[i].done));
      check({tag, ":data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         t0;
    logic [7:0] b;
    int         sl;
    bit         pb;
    n_tests = 0;
    n_fail  = 0;
    Reset   = 1'b1;
    Rx      = 1'b1;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_data", 32'(Data_byte), 32'h0);
    check("rst_rf",   32'(Receive_flag), 32'h0);
    check("rst_err",  32'(Frame_error), 32'h0);
    check("rst_hdr",  32'(Is_header), 32'h0);
    check("rst_done", 32'(Frame_done), 32'h0);
    Reset = 1'b0;
    wait_cycles(4);
    check("idle_busy", 32'(Busy), 32'h0);

    // Reset in the middle of a byte.
    t0 = cyc;
    Rx = 1'b0;
    wait_until(t0 + 72);
    check("mid_busy", 32'(Busy), 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_busy", 32'(Busy), 32'h0);
    check("mid_rst_rf",   32'(Receive_flag), 32'h0);
    Reset = 1'b0;
    Rx    = 1'b1;
    model_reset();
    wait_cycles(3 * int'(CPB));
    verify("reset_mid");
    send_byte(8'h41, 0, 1'b0);
    wait_cycles(4);
    verify("after_reset");
    do_reset();

    // Back-to-back frame: length 3 then 'a','b','a'.
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h61, 0, 1'b0);
    send_byte(8'h62, 0, 1'b0);
    send_byte(8'h61, 0, 1'b0);
    wait_cycles(4);
    verify("frame_aba");

    // Zero-length frame, then the next byte is a header again.
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hC3, 0, 1'b0);
    wait_cycles(4);
    verify("zero_len");

    // Stop bit held low for three bit times.
    send_byte(8'h55, 3, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    wait_cycles(4);
    verify("stop_err");

    // Short low glitch while idle.
    t0 = cyc;
    Rx = 1'b0;
    wait_cycles(3);
    Rx = 1'b1;
    check("glitch_busy", 32'(Busy), 32'h1);
    wait_until(t0 + 3 + int'(H));
    check("glitch_idle", 32'(Busy), 32'h0);
    wait_cycles(int'(CPB));
    verify("glitch");

`ifdef PARITY_RX_EN
    send_byte(8'h07, 0, 1'b1);
    send_byte(8'h07, 0, 1'b0);
    wait_cycles(4);
    verify("parity");
    do_reset();
`endif

    // Randomized traffic: small headers, random payload, occasional errors and gaps.
    for (int i = 0; i < 40; i++) begin
      b  = m_in_frame ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      pb = ($urandom_range(0, 7) == 0);
`ifndef PARITY_RX_EN
      pb = 1'b0;
`endif
      send_byte(b, sl, pb);
      if ($urandom_range(0, 1) == 1) wait_cycles(int'($urandom_range(1, 20)));
    end
    wait_cycles(4);
    verify("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
